// File: rtl/bcd_diff_display_driver_if.sv
// ---------------------------------------------------------------------------
// bcd_diff_display_driver_if
// Bundles the result-capture inputs and the display outputs of the BCD
// difference display driver.
//   load      : one-cycle capture strobe
//   diff_bcd  : two-digit BCD difference, [7:4] tens, [3:0] units
//   eac       : end-around carry, 1 = non-negative, 0 = negative
//   blank_lz  : 1 = blank the tens digit when it is zero (live, not captured)
//   seg       : segments {g,f,e,d,c,b,a}
//   an        : digit enables, [0] units, [1] tens, [2] sign
//   valid     : a result has been captured since reset
//   digit_err : captured value holds a nibble above 9
// master = producer of the result / viewer of the display, slave = driver.
// ---------------------------------------------------------------------------
interface bcd_diff_display_driver_if;
    logic       load;
    logic [7:0] diff_bcd;
    logic       eac;
    logic       blank_lz;
    logic [6:0] seg;
    logic [2:0] an;
    logic       valid;
    logic       digit_err;

    modport master (
        output load, diff_bcd, eac, blank_lz,
        input  seg, an, valid, digit_err
    );

    modport slave (
        input  load, diff_bcd, eac, blank_lz,
        output seg, an, valid, digit_err
    );
endinterface

// File: rtl/bcd_diff_display_driver.sv
// ---------------------------------------------------------------------------
// bcd_diff_display_driver
// Captures a two-digit BCD difference plus its sign and scans it onto a
// 3-digit multiplexed seven-segment display (sign, tens, units).
// Each digit slot lasts REFRESH_DIV cycles; the first GUARD cycles of every
// slot keep all anodes off so the previous digit cannot ghost into the next.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : bcd_diff_display_driver_if.slave (capture inputs, display outputs)
// seg/an are registered, one cycle behind the scan/captured state, and are
// inverted when ACTIVE_LOW = 1 (common-anode board).
// ---------------------------------------------------------------------------
module bcd_diff_display_driver #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned GUARD       = 16,
    parameter bit          ACTIVE_LOW  = 1'b1
) (
    input logic                       clk,
    input logic                       rst,
    bcd_diff_display_driver_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_CNT = CNT_W'(GUARD);

    // XOR masks that turn a logical pattern into the board's drive level;
    // they are also the "everything off" levels.
    localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'b111_1111 : 7'b000_0000;
    localparam logic [2:0] AN_OFF  = ACTIVE_LOW ? 3'b111 : 3'b000;

    localparam logic [6:0] SEG_MINUS = 7'b100_0000;
    localparam logic [6:0] SEG_E     = 7'b111_1001;

    logic [CNT_W-1:0] div_cnt_r;
    logic [1:0]       slot_r;
    logic [7:0]       val_r;
    logic             neg_r;
    logic             valid_r;
    logic             digit_err_r;
    logic [6:0]       seg_r;
    logic [2:0]       an_r;

    logic             wrap_s;
    logic [6:0]       seg_logic_s;
    logic [2:0]       an_logic_s;

    // BCD nibble to segment code {g..a}; non-decimal nibbles show 'E'.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] code;
        case (nib)
            4'd0:    code = 7'b011_1111;
            4'd1:    code = 7'b000_0110;
            4'd2:    code = 7'b101_1011;
            4'd3:    code = 7'b100_1111;
            4'd4:    code = 7'b110_0110;
            4'd5:    code = 7'b110_1101;
            4'd6:    code = 7'b111_1101;
            4'd7:    code = 7'b000_0111;
            4'd8:    code = 7'b111_1111;
            4'd9:    code = 7'b110_1111;
            default: code = SEG_E;
        endcase
        return code;
    endfunction

    // A BCD nibble is out of range when it exceeds 9.
    function automatic logic nibble_bad(input logic [3:0] nib);
        return (nib > 4'd9);
    endfunction

    assign wrap_s = (div_cnt_r == DIV_LAST);

    // Refresh divider and digit-slot sequencer (0 -> 1 -> 2 -> 0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_r <= '0;
            slot_r    <= 2'd0;
        end else if (wrap_s) begin
            div_cnt_r <= '0;
            case (slot_r)
                2'd0:    slot_r <= 2'd1;
                2'd1:    slot_r <= 2'd2;
                default: slot_r <= 2'd0;
            endcase
        end else begin
            div_cnt_r <= div_cnt_r + CNT_W'(1);
        end
    end

    // Result capture; independent of the scan so a load never restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_r       <= 8'h00;
            neg_r       <= 1'b0;
            valid_r     <= 1'b0;
            digit_err_r <= 1'b0;
        end else if (bus.load) begin
            val_r       <= bus.diff_bcd;
            neg_r       <= ~bus.eac;
            valid_r     <= 1'b1;
            digit_err_r <= nibble_bad(bus.diff_bcd[7:4]) | nibble_bad(bus.diff_bcd[3:0]);
        end
    end

    // Logical anode/segment pattern for the current slot, dark during guard.
    always_comb begin
        seg_logic_s = 7'b000_0000;
        an_logic_s  = 3'b000;
        if (valid_r && (div_cnt_r >= GUARD_CNT)) begin
            case (slot_r)
                2'd0: begin
                    an_logic_s  = 3'b001;
                    seg_logic_s = seg_decode(val_r[3:0]);
                end
                2'd1: begin
                    an_logic_s = 3'b010;
                    if ((val_r[7:4] == 4'd0) && bus.blank_lz) begin
                        seg_logic_s = 7'b000_0000;
                    end else begin
                        seg_logic_s = seg_decode(val_r[7:4]);
                    end
                end
                2'd2: begin
                    an_logic_s = 3'b100;
                    if (neg_r) begin
                        seg_logic_s = SEG_MINUS;
                    end else begin
                        seg_logic_s = 7'b000_0000;
                    end
                end
                default: begin
                    an_logic_s  = 3'b000;
                    seg_logic_s = 7'b000_0000;
                end
            endcase
        end else begin
            seg_logic_s = 7'b000_0000;
            an_logic_s  = 3'b000;
        end
    end

    // Output registers with board polarity applied.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_r <= SEG_OFF;
            an_r  <= AN_OFF;
        end else begin
            seg_r <= seg_logic_s ^ SEG_OFF;
            an_r  <= an_logic_s ^ AN_OFF;
        end
    end

    assign bus.seg       = seg_r;
    assign bus.an        = an_r;
    assign bus.valid     = valid_r;
    assign bus.digit_err = digit_err_r;

endmodule
